// File: rtl/reg_mux_skew.sv
// Purpose : registered NUM_SRC-way operand selector with optional per-lane diagonal skew feeding a systolic array edge.
// Latency : aligned mode 1 cycle on every lane; skew mode 1+l cycles for lane l.
// Backpressure: none; accepts one beat per cycle; en=0 flushes all in-flight data.
//
// Ports:
//   clk, sys_rst (async, active-low)   clock and reset
//   en                                 synchronous enable, 0 flushes the block
//   sel / din / din_valid              source select, flattened sources, beat present
//   skew_en                            mode request, latched only when the block is idle
//   dout / dout_valid                  per-lane data (zero when not valid) and valids
//   busy                               pipeline holds undelivered data
//   sel_err                            pulse with lane 0 of a beat whose sel is out of range
module reg_mux_skew #(
    parameter int RSA_DW  = 16,
    parameter int NUM_SRC = 4,
    parameter int LANES   = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                              clk,
    input  logic                              sys_rst,
    input  logic                              en,
    input  logic [SEL_W-1:0]                  sel,
    input  logic [NUM_SRC*LANES*RSA_DW-1:0]   din,
    input  logic                              din_valid,
    input  logic                              skew_en,
    output logic [LANES*RSA_DW-1:0]           dout,
    output logic [LANES-1:0]                  dout_valid,
    output logic                              busy,
    output logic                              sel_err
);

    // Delay lines form a triangle: lane l owns l registers, lane 0 none.
    // Register k of lane l lives at index l*(l-1)/2 + k.
    localparam int NTRI   = LANES * (LANES - 1) / 2;
    localparam int NTRI_A = (NTRI > 0) ? NTRI : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    logic [RSA_DW-1:0] s0_dat_q  [LANES];
    logic [RSA_DW-1:0] s0_dat_d  [LANES];
    logic              s0_vld_q, s0_vld_d;
    logic              s0_err_q, s0_err_d;
    logic [RSA_DW-1:0] dly_dat_q [NTRI_A];
    logic [RSA_DW-1:0] dly_dat_d [NTRI_A];
    logic [NTRI_A-1:0] dly_vld_q, dly_vld_d;
    state_t            state_q, state_d;
    logic              mode_q, mode_d;   // 1 = skew, latched at IDLE->RUN

    // Datapath next-state: stage 0 capture and delay-line shift.
    always_comb begin
        s0_vld_d  = 1'b0;
        s0_err_d  = 1'b0;
        dly_vld_d = '0;
        for (int l = 0; l < LANES; l++) begin
            s0_dat_d[l] = '0;
        end
        for (int i = 0; i < NTRI_A; i++) begin
            dly_dat_d[i] = '0;
        end

        if (en) begin
            s0_vld_d = din_valid;
            if (din_valid) begin
                // An out-of-range select still forms a valid beat, but with zero data.
                s0_err_d = 1'b1;
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (int'(sel) == s) begin
                        s0_err_d = 1'b0;
                        for (int l = 0; l < LANES; l++) begin
                            s0_dat_d[l] = din[(s*LANES+l)*RSA_DW +: RSA_DW];
                        end
                    end
                end
                if (s0_err_d) begin
                    for (int l = 0; l < LANES; l++) begin
                        s0_dat_d[l] = '0;
                    end
                end
            end

            // Delay lines only carry data in skew mode, so aligned bursts never
            // keep the FSM out of IDLE after stage 0 empties.
            for (int l = 1; l < LANES; l++) begin
                for (int k = 0; k < l; k++) begin
                    if (k == 0) begin
                        dly_vld_d[l*(l-1)/2] = s0_vld_q & mode_q;
                        dly_dat_d[l*(l-1)/2] = (s0_vld_q & mode_q) ? s0_dat_q[l] : '0;
                    end else begin
                        dly_vld_d[l*(l-1)/2+k] = dly_vld_q[l*(l-1)/2+k-1];
                        dly_dat_d[l*(l-1)/2+k] = dly_dat_q[l*(l-1)/2+k-1];
                    end
                end
            end
        end
    end

    // Control FSM and mode latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        if (!en) begin
            state_d = IDLE;
            mode_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (din_valid) begin
                        state_d = RUN;
                        mode_d  = skew_en;
                    end
                end
                RUN, DRAIN: begin
                    if (din_valid) begin
                        state_d = RUN;
                    end else if (|dly_vld_d) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
            s0_vld_q  <= 1'b0;
            s0_err_q  <= 1'b0;
            dly_vld_q <= '0;
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            for (int l = 0; l < LANES; l++) begin
                s0_dat_q[l] <= '0;
            end
            for (int i = 0; i < NTRI_A; i++) begin
                dly_dat_q[i] <= '0;
            end
        end else begin
            s0_vld_q  <= s0_vld_d;
            s0_err_q  <= s0_err_d;
            dly_vld_q <= dly_vld_d;
            state_q   <= state_d;
            mode_q    <= mode_d;
            for (int l = 0; l < LANES; l++) begin
                s0_dat_q[l] <= s0_dat_d[l];
            end
            for (int i = 0; i < NTRI_A; i++) begin
                dly_dat_q[i] <= dly_dat_d[i];
            end
        end
    end

    // Output select: lane 0 always comes from stage 0; other lanes come from
    // stage 0 (aligned) or the tail of their delay line (skew). Idle lanes read 0.
    always_comb begin
        dout       = '0;
        dout_valid = '0;
        dout_valid[0]         = s0_vld_q;
        dout[0 +: RSA_DW]     = s0_vld_q ? s0_dat_q[0] : '0;
        for (int l = 1; l < LANES; l++) begin
            if (mode_q) begin
                dout_valid[l]              = dly_vld_q[l*(l-1)/2+l-1];
                dout[l*RSA_DW +: RSA_DW]   = dly_vld_q[l*(l-1)/2+l-1] ? dly_dat_q[l*(l-1)/2+l-1] : '0;
            end else begin
                dout_valid[l]              = s0_vld_q;
                dout[l*RSA_DW +: RSA_DW]   = s0_vld_q ? s0_dat_q[l] : '0;
            end
        end
    end

    assign busy    = (state_q != IDLE);
    assign sel_err = s0_err_q;

endmodule

// File: doc/reg_mux_skew.md
# reg_mux_skew

Registered N-source, multi-lane selector feeding the RSA systolic array edge. It picks one of `NUM_SRC` operand vectors, registers it, and optionally applies diagonal skew so that lane `l` reaches the array `l` cycles after lane 0. Per-lane valids, zero-fill on idle lanes, a busy/drain state machine and sticky mode latching let a controller stream bursts without tracking pipeline depth.

## Interface
- `RSA_DW`, 16, data width per lane (signed)
- `NUM_SRC`, 4, number of selectable sources (≥2)
- `LANES`, 4, lanes per source vector (≥1)
- `SEL_W`, `$clog2(NUM_SRC)`, derived select width
- `clk`  in  1  system clock, all state on rising edge
- `sys_rst`  in  1  reset, asynchronous, active-low
- `en`  in  1  synchronous enable; 0 flushes block
- `sel`  in  SEL_W  source select, sampled with `din_valid`
- `din`  in  NUM_SRC*LANES*RSA_DW  flattened signed sources; source s lane l at `[(s*LANES+l)*RSA_DW +: RSA_DW]`
- `din_valid`  in  1  beat present this cycle
- `skew_en`  in  1  mode request: 1 = diagonal skew, 0 = aligned
- `dout`  out  LANES*RSA_DW  signed lane outputs, lane l at `[l*RSA_DW +: RSA_DW]`
- `dout_valid`  out  LANES  per-lane valid
- `busy`  out  1  pipeline holds undelivered data
- `sel_err`  out  1  one-cycle pulse: beat accepted with `sel >= NUM_SRC`

## Operation
- Stage 0: on edge with `en=1`, `din_valid=1`: all lanes of source `sel` captured with valid=1. With `din_valid=0`: stage 0 loads zeros, valid=0.
- `sel >= NUM_SRC` (non-power-of-2 NUM_SRC): beat still accepted with valid=1, data forced to 0, `sel_err`=1 in the cycle its stage-0 data is presented.
- Aligned mode: stage 0 drives `dout` directly, all lanes.
- Skew mode: lane l passes through l additional registers (data and valid) after stage 0; lane 0 has none.
- Any lane whose valid is 0 outputs exactly 0 (zero-fill for PEs).
- FSM `IDLE`/`RUN`/`DRAIN`:
  - IDLE→RUN: edge with `din_valid=1`; mode latched from `skew_en` at this edge.
  - RUN→DRAIN: edge with `din_valid=0` while any delay-line valid (after that edge) is 1.
  - RUN→IDLE or DRAIN→IDLE: edge after which no valid bit remains anywhere in stage 0 or delay lines.
  - DRAIN→RUN: edge with `din_valid=1`; latched mode kept.
  - Aligned mode never enters DRAIN.
- `skew_en` ignored outside IDLE; mode change only takes effect after full drain.
- `busy` = (state != IDLE), registered.
- `en=0` on an edge: all stage-0/delay registers, `dout`, `dout_valid`, `sel_err` cleared, state→IDLE, latched mode→0; input beat discarded. Dominates `din_valid`.
- `sys_rst=0`: immediately (asynchronous) all outputs 0, state IDLE, latched mode 0.

## Timing
- Beat sampled at edge E: lane l valid in cycle following edge E (aligned) or edge E+l (skew).
- Latency aligned: 1 cycle all lanes; skew: 1+l for lane l.
- Throughput one beat per cycle, back-to-back, no bubbles, any mode.
- `busy` rises the cycle after first accepted beat; falls the cycle after the last lane's last valid cycle (skew: cycle after E_last+LANES-1; aligned: cycle after E_last).
- `sel_err` coincides with lane 0 valid of offending beat.
- Reset values: `dout`=0, `dout_valid`=0, `busy`=0, `sel_err`=0.

## Test plan
(NUM_SRC=4, LANES=4, RSA_DW=16)
- Aligned single beat: `skew_en=0`, sel=2, src2 lanes 0x0011..0x0014, valid at E -> cycle after E `dout`=0x0014_0013_0012_0011, `dout_valid`=4'b1111; next cycle all 0, `busy`=0.
- Skew burst: `skew_en=1`, sel=1, 3 beats lanes=k*0x10+l at E..E+2 -> lane l shows beats 0,1,2 after edges E+l..E+l+2; lane 3 last valid after E+5; `busy` 1 through that cycle, 0 after; zero-fill elsewhere.
- Mode change while busy: start skew burst, toggle `skew_en`=0 mid-burst, new beat during DRAIN -> still skewed; after IDLE, next beat aligned.
- Negative data/select switching: alternate sel 0/3 each cycle with 0x8000/0x7FFF patterns -> outputs bit-exact, no cross-source mixing.
- `en` flush: `en`=0 one edge mid skew burst -> next cycle all `dout`/`dout_valid`=0, `busy`=0; remaining in-flight beats never appear.
- Async reset: assert `sys_rst`=0 between edges mid burst -> outputs 0 immediately without clock; after release, first beat behaves as fresh aligned/skew per `skew_en`.
